wb_spi_slave: RTL and testbench

Wishbone-attached SPI slave (mode 0, 8-bit frames, MSB first), the responder counterpart of the SoC's SPI master peripheral. An external SPI master, or a second board running the same firmware, addresses the LM32 through this block. Received bytes land in an RX FIFO and transmit bytes are supplied through a holding register. The block sits on the conbus as an ordinary 32-bit slave.

---
 rtl/wb_spi_slave.sv | 218 +++++++++++++++++++++
 tb/tb_wb_spi_slave.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_slave.sv
// Wishbone-attached SPI slave: mode 0, 8-bit MSB-first frames, RX FIFO, TX holding register.
// Define WB_SPI_SLAVE_IRQ_EN to add the IRQEN register and the registered intr output.
module wb_spi_slave #(
    parameter int fifo_depth = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
`ifdef WB_SPI_SLAVE_IRQ_EN
    ,
    output logic        intr
`endif
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state_q, state_d;

    logic [1:0]    sck_sync_q, cs_sync_q, mosi_sync_q;
    logic          sck_prev_q, sck_prev_d, cs_prev_q, cs_prev_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic          skip_fall_q, skip_fall_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_o_q, dat_o_d;
    logic          oe_q, oe_d;
    logic [7:0]    fifo_mem [fifo_depth];
    logic [1:0]    irqen_q, irqen_d;
    logic          intr_q, intr_d;

    logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall, in_shift;
    logic wb_fire, wr_fire, rd_fire, fifo_full, rx_avail, pop, byte_done, push, overrun_set;
    logic [1:0] reg_sel;
    logic [7:0] rx_head, rx_byte;

    // Synchronizers are left unreset so a reset with CS held low cannot fake a CS falling edge.
    always_ff @(posedge clk) begin
        sck_sync_q  <= {sck_sync_q[0], spi_sck};
        cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
        mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end

    assign sck_s     = sck_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign in_shift  = (state_q == SHIFT) && !cs_s;

    assign wb_fire   = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr_fire   = wb_fire & wb_we_i;
    assign rd_fire   = wb_fire & ~wb_we_i;
    assign reg_sel   = wb_adr_i[3:2];

    assign fifo_full   = (count_q == CW'(fifo_depth));
    assign rx_avail    = (count_q != '0);
    assign rx_head     = rx_avail ? fifo_mem[rd_ptr_q] : 8'h00;
    assign rx_byte     = {rx_shift_q[6:0], mosi_s};
    assign pop         = rd_fire && (reg_sel == 2'd0) && rx_avail;
    assign byte_done   = in_shift && sck_rise && (bitcnt_q == 3'd7);
    assign push        = byte_done && (!fifo_full || pop);
    assign overrun_set = byte_done && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_s)         state_d = IDLE;
        else if (cs_fall) state_d = SHIFT;
    end

    always_comb begin
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        bitcnt_d    = bitcnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        skip_fall_d = skip_fall_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        irqen_d     = irqen_q;
        ack_d       = wb_fire;
        dat_o_d     = 32'h0;
        oe_d        = ~cs_s;

        if (cs_fall) begin
            tx_shift_d  = hold_full_q ? hold_q : 8'h00;
            hold_full_d = 1'b0;
            bitcnt_d    = 3'd0;
            skip_fall_d = 1'b0;
        end else if (in_shift && sck_rise) begin
            rx_shift_d = rx_byte;
            bitcnt_d   = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
                tx_shift_d  = hold_full_q ? hold_q : 8'h00;
                hold_full_d = 1'b0;
                skip_fall_d = 1'b1;
            end
        end else if (in_shift && sck_fall) begin
            // The freshly reloaded bit 7 must survive until the next rising edge.
            if (skip_fall_q) skip_fall_d = 1'b0;
            else             tx_shift_d  = {tx_shift_q[6:0], 1'b0};
        end

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_fire && reg_sel == 2'd2 && wb_dat_i[3]) overrun_d = 1'b0;
        if (overrun_set)                               overrun_d = 1'b1;

        if (wr_fire && reg_sel == 2'd1) begin
            hold_d      = wb_dat_i[7:0];
            hold_full_d = 1'b1;
        end
`ifdef WB_SPI_SLAVE_IRQ_EN
        if (wr_fire && reg_sel == 2'd3) irqen_d = wb_dat_i[1:0];
`endif

        if (rd_fire) begin
            case (reg_sel)
                2'd0:    dat_o_d = {24'h0, rx_head};
                2'd2:    dat_o_d = {27'h0, oe_q, overrun_q, ~hold_full_q, fifo_full, rx_avail};
                2'd3:    dat_o_d = {30'h0, irqen_q};
                default: dat_o_d = 32'h0;
            endcase
        end

        intr_d = (rx_avail & irqen_q[0]) | (~hold_full_q & irqen_q[1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
            bitcnt_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            tx_shift_q  <= 8'h00;
            skip_fall_q <= 1'b0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            irqen_q     <= 2'b00;
            intr_q      <= 1'b0;
            ack_q       <= 1'b0;
            dat_o_q     <= 32'h0;
            oe_q        <= 1'b0;
        end else begin
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            bitcnt_q    <= bitcnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            skip_fall_q <= skip_fall_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            irqen_q     <= irqen_d;
            intr_q      <= intr_d;
            ack_q       <= ack_d;
            dat_o_q     <= dat_o_d;
            oe_q        <= oe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= rx_byte;
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_o_q;
    assign spi_miso    = tx_shift_q[7];
    assign spi_miso_oe = oe_q;
`ifdef WB_SPI_SLAVE_IRQ_EN
    assign intr        = intr_q;
`endif

    logic unused_ok;
    assign unused_ok = &{1'b0, wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], intr_q};

endmodule

// File: tb/tb_wb_spi_slave.sv
// Self-checking bench for wb_spi_slave: register table, SPI master model and scoreboard.
module tb_wb_spi_slave;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic [3:0]  wb_sel_i;
    logic        spi_sck, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
`ifdef WB_SPI_SLAVE_IRQ_EN
    logic        intr;
`endif

    wb_spi_slave #(.fifo_depth(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
`ifdef WB_SPI_SLAVE_IRQ_EN
        , .intr(intr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    typedef struct {
        bit          we;
        logic [1:0]  idx;
        logic [31:0] wdata;
        logic [31:0] want;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int compared = 0;
    int mismatched = 0;

    localparam logic [1:0] RXDATA = 2'd0, TXDATA = 2'd1, STATUS = 2'd2, IRQEN = 2'd3;

    task automatic expectValue(input string name, input logic [31:0] value);
        exp_t e;
        e.name = name;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] actual);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty got=0x%08h", actual);
        end else begin
            e = sb.pop_front();
            if (actual !== e.value) begin
                mismatched++;
                $display("[TB] FAIL %s got=0x%08h want=0x%08h", e.name, actual, e.value);
            end
        end
    endtask

    task automatic checkNow(input string name, input logic [31:0] actual, input logic [31:0] want);
        compared++;
        if (actual !== want) begin
            mismatched++;
            $display("[TB] FAIL %s got=0x%08h want=0x%08h", name, actual, want);
        end
    endtask

    task automatic wbAccess(input bit we, input logic [1:0] idx, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        bit got;
        @(posedge clk); #1;
        wb_adr_i = {28'h0, idx, 2'b00};
        wb_dat_i = wdata;
        wb_we_i  = we;
        wb_sel_i = 4'hF;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) got = 1'b1;
        end
        rdata    = wb_dat_o;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wb_ack_timeout got=0 want=1");
        end
    endtask

    task automatic wbRead(input logic [1:0] idx, input string name, input logic [31:0] want);
        logic [31:0] r;
        expectValue(name, want);
        wbAccess(1'b0, idx, 32'h0, r);
        checkOutput(r);
    endtask

    task automatic wbWrite(input logic [1:0] idx, input logic [31:0] data);
        logic [31:0] r;
        wbAccess(1'b1, idx, data, r);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.we) wbWrite(v.idx, v.wdata);
        else      wbRead(v.idx, v.name, v.want);
    endtask

    // Master side: SCK half period of 8 clk cycles, MISO sampled on the rising edge.
    task automatic spiBit(input logic mo, output logic mi);
        spi_mosi = mo;
        repeat (8) @(posedge clk);
        #1 spi_sck = 1'b1;
        mi = spi_miso;
        repeat (8) @(posedge clk);
        #1 spi_sck = 1'b0;
    endtask

    task automatic spiByte(input logic [7:0] mo, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) spiBit(mo[i], mi[i]);
    endtask

    task automatic csLow(input string name, input logic first_bit);
        @(posedge clk); #1 spi_cs_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkNow(name, {31'h0, spi_miso}, {31'h0, first_bit});
    endtask

    task automatic csHigh();
        @(posedge clk); #1 spi_cs_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        logic [7:0]  mi;
        logic [31:0] r;
        int acks;

        reset = 1'b1;
        wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkNow("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        checkNow("rst_miso_oe", {30'h0, spi_miso, spi_miso_oe}, 32'h0);
        reset = 1'b0;

        vecs.push_back('{0, STATUS, 32'h0,  32'h04, "rst_status"});
        vecs.push_back('{0, RXDATA, 32'h0,  32'h00, "rst_rxdata"});
        vecs.push_back('{0, TXDATA, 32'h0,  32'h00, "txdata_reads_zero"});
        vecs.push_back('{0, IRQEN,  32'h0,  32'h00, "rst_irqen"});
        vecs.push_back('{1, TXDATA, 32'h5A, 32'h00, ""});
        vecs.push_back('{0, STATUS, 32'h0,  32'h00, "status_tx_full"});
        vecs.push_back('{1, TXDATA, 32'hA5, 32'h00, ""});
        vecs.push_back('{1, RXDATA, 32'hFF, 32'h00, ""});
        vecs.push_back('{1, STATUS, 32'h08, 32'h00, ""});
        vecs.push_back('{0, STATUS, 32'h0,  32'h00, "status_after_writes"});
        vecs.push_back('{0, RXDATA, 32'h0,  32'h00, "rxdata_still_empty"});
        vecs.push_back('{1, IRQEN,  32'h3,  32'h00, ""});
`ifdef WB_SPI_SLAVE_IRQ_EN
        vecs.push_back('{0, IRQEN,  32'h0,  32'h03, "irqen_readback"});
`else
        vecs.push_back('{0, IRQEN,  32'h0,  32'h00, "irqen_absent"});
`endif
        vecs.push_back('{1, IRQEN,  32'h0,  32'h00, ""});
        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Single frame: overwritten holding byte goes out, 0x3C comes in.
        csLow("csfall_miso_bit7", 1'b1);
        checkNow("miso_oe_active", {31'h0, spi_miso_oe}, 32'h1);
        expectValue("frameA_miso", 32'hA5);
        spiByte(8'h3C, mi);
        checkOutput({24'h0, mi});
        csHigh();
        wbRead(STATUS, "frameA_status", 32'h05);
        wbRead(RXDATA, "frameA_rxdata", 32'h3C);
        wbRead(STATUS, "frameA_status_after", 32'h04);

        // Two-byte frame with a TXDATA write landing during the first byte.
        wbWrite(TXDATA, 32'h81);
        fork
            begin
                csLow("frameB_bit7", 1'b1);
                expectValue("frameB_miso0", 32'h81);
                spiByte(8'h55, mi);
                checkOutput({24'h0, mi});
                expectValue("frameB_miso1", 32'hC3);
                spiByte(8'hAA, mi);
                checkOutput({24'h0, mi});
                csHigh();
            end
            begin
                repeat (60) @(posedge clk);
                wbWrite(TXDATA, 32'hC3);
            end
        join
        wbRead(RXDATA, "frameB_rx0", 32'h55);
        wbRead(RXDATA, "frameB_rx1", 32'hAA);
        wbRead(STATUS, "frameB_status", 32'h04);

        // Overrun: depth+1 bytes with the holding register empty.
        csLow("frameC_bit7", 1'b0);
        for (int i = 0; i <= DEPTH; i++) begin
            expectValue($sformatf("frameC_miso%0d", i), 32'h00);
            spiByte(8'h10 + 8'(i), mi);
            checkOutput({24'h0, mi});
        end
        csHigh();
        wbRead(STATUS, "overrun_status", 32'h0F);
        for (int i = 0; i < DEPTH; i++)
            wbRead(RXDATA, $sformatf("overrun_rx%0d", i), 32'h10 + 32'(i));
        wbRead(STATUS, "overrun_drained", 32'h0C);
        wbWrite(STATUS, 32'h08);
        wbRead(STATUS, "overrun_cleared", 32'h04);

        // Partial byte discarded when CS rises early.
        csLow("frameD_bit7", 1'b0);
        for (int i = 0; i < 5; i++) spiBit(1'b1, mi[0]);
        csHigh();
        csLow("frameE_bit7", 1'b0);
        expectValue("frameE_miso", 32'h00);
        spiByte(8'h12, mi);
        checkOutput({24'h0, mi});
        csHigh();
        wbRead(STATUS, "partial_status", 32'h05);
        wbRead(RXDATA, "partial_rx", 32'h12);
        wbRead(RXDATA, "partial_rx_empty", 32'h00);
        wbRead(STATUS, "partial_status_after", 32'h04);

        // Strobe held high: ack pulses every other cycle.
        @(posedge clk); #1;
        wb_adr_i = 32'h8; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) acks++;
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        checkNow("ack_every_other", 32'(acks), 32'd2);

        // Reset mid-frame: later SCK edges are ignored until a fresh CS fall.
        wbWrite(TXDATA, 32'hFF);
        csLow("frameF_bit7", 1'b1);
        for (int i = 0; i < 3; i++) spiBit(1'b1, mi[0]);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkNow("miso_after_reset", {31'h0, spi_miso}, 32'h0);
        for (int i = 0; i < 8; i++) spiBit(1'b1, mi[0]);
        csHigh();
        wbRead(STATUS, "midreset_status", 32'h04);
        wbRead(RXDATA, "midreset_rx", 32'h00);

`ifdef WB_SPI_SLAVE_IRQ_EN
        wbWrite(IRQEN, 32'h1);
        checkNow("intr_idle", {31'h0, intr}, 32'h0);
        csLow("frameG_bit7", 1'b0);
        spiByte(8'h77, mi);
        csHigh();
        checkNow("intr_rx_avail", {31'h0, intr}, 32'h1);
        expectValue("irq_rxdata", 32'h77);
        wbAccess(1'b0, RXDATA, 32'h0, r);
        checkOutput(r);
        @(posedge clk); #1;
        checkNow("intr_after_pop", {31'h0, intr}, 32'h0);
        wbWrite(IRQEN, 32'h2);
        @(posedge clk); #1;
        checkNow("intr_tx_empty", {31'h0, intr}, 32'h1);
        wbWrite(IRQEN, 32'h0);
`endif

        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog_timeout got=expired want=finished");
        $fatal(1, "[TB] watchdog");
    end

endmodule
